// File: rtl/bg_vram_arbiter.sv
// Single-port BG VRAM arbiter: display fetches and CPU accesses share one port, with starvation forcing for the CPU.
// Optional one-entry posted CPU write buffer is compiled in by defining BG_ARB_WBUF_EN.
module bg_vram_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 9,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [1:0] OWN_IDLE   = 2'd0;
    localparam logic [1:0] OWN_DISP   = 2'd1;
    localparam logic [1:0] OWN_CPU_RD = 2'd2;
    localparam logic [1:0] OWN_CPU_WR = 2'd3;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]        owner_reg, owner_next;
    logic [3:0]        starve_reg, starve_next;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [DATA_W-1:0] disp_data_reg, cpu_rdata_reg;
    logic              forced, grant_disp, grant_cpu, grant_drain, grant_we, port_busy;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_din;

`ifdef BG_ARB_WBUF_EN
    logic              wbuf_full_reg;
    logic [ADDR_W-1:0] wbuf_addr_reg;
    logic [DATA_W-1:0] wbuf_data_reg;
    logic              accept_wr;

    // Writes never touch the port directly; they are posted and drained later.
    // A forced slot with the buffer full is spent on the drain, which unblocks the CPU.
    always_comb begin
        accept_wr   = !rst && cpu_req && cpu_we && !wbuf_full_reg;
        forced      = !rst && cpu_req && !accept_wr && (starve_reg == STARVE_LIM);
        grant_disp  = !rst && disp_req && !forced;
        grant_drain = !rst && wbuf_full_reg && (forced || !disp_req);
        grant_cpu   = !rst && cpu_req && !cpu_we && !wbuf_full_reg && (forced || !disp_req);
        cpu_ack     = accept_wr || grant_cpu;
        grant_we    = grant_drain;
        grant_din   = wbuf_data_reg;
        grant_addr  = cpu_addr;
        if (grant_drain) begin
            grant_addr = wbuf_addr_reg;
        end else if (grant_disp) begin
            grant_addr = disp_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbuf_full_reg <= 1'b0;
            wbuf_addr_reg <= '0;
            wbuf_data_reg <= '0;
        end else if (accept_wr) begin
            wbuf_full_reg <= 1'b1;
            wbuf_addr_reg <= cpu_addr;
            wbuf_data_reg <= cpu_wdata;
        end else if (grant_drain) begin
            wbuf_full_reg <= 1'b0;
        end
    end
`else
    always_comb begin
        forced      = !rst && cpu_req && (starve_reg == STARVE_LIM);
        grant_disp  = !rst && disp_req && !forced;
        grant_cpu   = !rst && cpu_req && (forced || !disp_req);
        grant_drain = 1'b0;
        cpu_ack     = grant_cpu;
        grant_we    = grant_cpu && cpu_we;
        grant_din   = cpu_wdata;
        grant_addr  = grant_disp ? disp_addr : cpu_addr;
    end
`endif

    always_comb begin
        port_busy = grant_disp || grant_cpu || grant_drain;
        ram_addr  = rst ? '0 : (port_busy ? grant_addr : addr_hold_reg);
        ram_we    = grant_we;
        ram_din   = grant_din;
        disp_miss = forced && disp_req;

        owner_next = OWN_IDLE;
        if (grant_disp) begin
            owner_next = OWN_DISP;
        end else if (grant_drain) begin
            owner_next = OWN_CPU_WR;
        end else if (grant_cpu) begin
            owner_next = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
        end

        starve_next = starve_reg;
        if (cpu_ack || grant_drain) begin
            starve_next = 4'd0;
        end else if (cpu_req && starve_reg != 4'hF) begin
            starve_next = starve_reg + 4'd1;
        end

        // Read returns are gated by rst so a reset discards anything in flight.
        disp_valid = !rst && (owner_reg == OWN_DISP);
        cpu_rvalid = !rst && (owner_reg == OWN_CPU_RD);
        disp_data  = rst ? '0 : (disp_valid ? ram_dout : disp_data_reg);
        cpu_rdata  = rst ? '0 : (cpu_rvalid ? ram_dout : cpu_rdata_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg     <= OWN_IDLE;
            starve_reg    <= 4'd0;
            addr_hold_reg <= '0;
            disp_data_reg <= '0;
            cpu_rdata_reg <= '0;
        end else begin
            owner_reg  <= owner_next;
            starve_reg <= starve_next;
            if (port_busy) begin
                addr_hold_reg <= grant_addr;
            end
            if (disp_valid) begin
                disp_data_reg <= ram_dout;
            end
            if (cpu_rvalid) begin
                cpu_rdata_reg <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_bg_vram_arbiter.sv
// Self-checking bench for bg_vram_arbiter: directed scenarios plus a randomized run against a port-level model.
// Exercises the posted write buffer scenarios when BG_ARB_WBUF_EN is defined.
module tb_bg_vram_arbiter;

    localparam int AW = 11;
    localparam int DW = 9;
    localparam int SM = 15;
    localparam int DEPTH = 1 << AW;
    localparam int W_NONE = 0, W_DISP = 1, W_CPU = 2, W_DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          disp_miss;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] ram [0:DEPTH-1];
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    int vectors = 0;
    int miscompares = 0;

    bg_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid),
        .disp_data(disp_data), .disp_miss(disp_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port VRAM with one-cycle registered read; the backdoor port preloads contents.
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req = 1'b0; disp_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        disp_req = 1'b1; disp_addr = 11'h155;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h2AA; cpu_wdata = 9'h1FF;
        @(negedge clk);
        vectors += 8;
        if (disp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_disp_valid: got %b expected 0", disp_valid); end
        if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_ack: got %b expected 0", cpu_ack); end
        if (cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_rvalid: got %b expected 0", cpu_rvalid); end
        if (disp_miss !== 1'b0) begin miscompares++; $display("FAIL reset_disp_miss: got %b expected 0", disp_miss); end
        if (ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        if (ram_addr !== '0) begin miscompares++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
        if (disp_data !== '0) begin miscompares++; $display("FAIL reset_disp_data: got %h expected 0", disp_data); end
        if (cpu_rdata !== '0) begin miscompares++; $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata); end
        tick();
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) begin
            bd_we = 1'b1; bd_addr = AW'(a); bd_data = DW'($urandom);
            tick();
        end
        bd_we = 1'b1; bd_addr = 11'h010; bd_data = 9'h1A5;
        tick();
        bd_we = 1'b0;
        rst = 1'b0;
        $display("reset: outputs idle, VRAM preloaded");
    endtask

    task automatic test_lone_read();
        pulse_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h010;
        @(negedge clk);
        vectors += 3;
        if (cpu_ack !== 1'b1) begin miscompares++; $display("FAIL lone_read_ack: got %b expected 1", cpu_ack); end
        if (ram_addr !== 11'h010) begin miscompares++; $display("FAIL lone_read_addr: got %h expected 010", ram_addr); end
        if (ram_we !== 1'b0) begin miscompares++; $display("FAIL lone_read_we: got %b expected 0", ram_we); end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        vectors += 3;
        if (cpu_rvalid !== 1'b1) begin miscompares++; $display("FAIL lone_read_rvalid: got %b expected 1", cpu_rvalid); end
        if (cpu_rdata !== 9'h1A5) begin miscompares++; $display("FAIL lone_read_rdata: got %h expected 1a5", cpu_rdata); end
        if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL lone_read_ack_drop: got %b expected 0", cpu_ack); end
        tick();
        $display("lone read 0x010 -> 0x%h", 9'h1A5);
    endtask

    // Display and CPU read held high: forced CPU slot every 16th cycle.
    task automatic test_starvation(input bit after_reset_check);
        logic [DW-1:0] dval, cval;
        bit prev_forced, forced_e;
        dval = ram[11'h055];
        cval = ram[11'h200];
        prev_forced = 1'b0;
        disp_req = 1'b1; disp_addr = 11'h055;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h200;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            forced_e = (k % 16 == 0);
            vectors += 3;
            if (cpu_ack !== forced_e) begin miscompares++; $display("FAIL starve_ack k=%0d: got %b expected %b", k, cpu_ack, forced_e); end
            if (disp_miss !== forced_e) begin miscompares++; $display("FAIL starve_miss k=%0d: got %b expected %b", k, disp_miss, forced_e); end
            if (ram_addr !== (forced_e ? 11'h200 : 11'h055)) begin miscompares++; $display("FAIL starve_addr k=%0d: got %h expected %h", k, ram_addr, forced_e ? 11'h200 : 11'h055); end
            if (k > 1 || after_reset_check) begin
                vectors += 2;
                if (disp_valid !== (k > 1 && !prev_forced)) begin miscompares++; $display("FAIL starve_dvalid k=%0d: got %b expected %b", k, disp_valid, (k > 1 && !prev_forced)); end
                if (cpu_rvalid !== (k > 1 && prev_forced)) begin miscompares++; $display("FAIL starve_cvalid k=%0d: got %b expected %b", k, cpu_rvalid, (k > 1 && prev_forced)); end
            end
            if (k > 1 && !prev_forced) begin
                vectors++;
                if (disp_data !== dval) begin miscompares++; $display("FAIL starve_ddata k=%0d: got %h expected %h", k, disp_data, dval); end
            end
            if (prev_forced) begin
                vectors++;
                if (cpu_rdata !== cval) begin miscompares++; $display("FAIL starve_cdata k=%0d: got %h expected %h", k, cpu_rdata, cval); end
            end
            if (forced_e) $display("starvation: forced CPU read at cycle %0d", k);
            prev_forced = forced_e;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write_slot();
        bit acked;
        bit ack_e;
        pulse_reset();
        acked = 1'b0;
        cpu_we = 1'b1; cpu_addr = 11'h123; cpu_wdata = 9'h0FF;
        for (int k = 0; k < 6; k++) begin
            disp_req = (k % 3 == 0);
            disp_addr = AW'(11'h300 + k);
            cpu_req = !acked;
            @(negedge clk);
`ifdef BG_ARB_WBUF_EN
            ack_e = (k == 0);
`else
            ack_e = (k == 1);
`endif
            vectors += 3;
            if (cpu_ack !== ack_e) begin miscompares++; $display("FAIL wslot_ack k=%0d: got %b expected %b", k, cpu_ack, ack_e); end
            if (disp_miss !== 1'b0) begin miscompares++; $display("FAIL wslot_miss k=%0d: got %b expected 0", k, disp_miss); end
            if (ram_we !== (k == 1)) begin miscompares++; $display("FAIL wslot_we k=%0d: got %b expected %b", k, ram_we, (k == 1)); end
            if (k == 0) begin
                vectors++;
                if (ram_addr !== 11'h300) begin miscompares++; $display("FAIL wslot_disp_addr: got %h expected 300", ram_addr); end
            end
            if (k == 1) begin
                vectors += 2;
                if (ram_addr !== 11'h123) begin miscompares++; $display("FAIL wslot_addr: got %h expected 123", ram_addr); end
                if (ram_din !== 9'h0FF) begin miscompares++; $display("FAIL wslot_din: got %h expected 0ff", ram_din); end
            end
            if (cpu_ack) acked = 1'b1;
            tick();
        end
        idle_inputs();
        $display("write slot: 0x0FF -> 0x123 in first free cycle");
    endtask

`ifdef BG_ARB_WBUF_EN
    task automatic test_back_to_back();
        bit            t_disp [0:8]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        bit            t_req  [0:8]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        bit            t_we   [0:8]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        logic [AW-1:0] t_addr [0:8]  = '{11'h040, 11'h041, 11'h041, 11'h041, 11'h041, 11'h041, 11'h041, 11'h041, 11'h000};
        logic [DW-1:0] t_wd   [0:8]  = '{9'h111, 9'h0AA, 9'h0AA, 9'h0AA, 9'h0AA, 9'h0AA, 9'h000, 9'h000, 9'h000};
        bit            e_ack  [0:8]  = '{1, 0, 0, 0, 0, 1, 0, 1, 0};
        bit            e_we   [0:8]  = '{0, 0, 0, 0, 1, 0, 1, 0, 0};
        logic [AW-1:0] e_addr [0:8]  = '{11'h7F0, 11'h7F0, 11'h7F0, 11'h7F0, 11'h040, 11'h040, 11'h041, 11'h041, 11'h041};
        logic [DW-1:0] e_din  [0:8]  = '{9'h000, 9'h000, 9'h000, 9'h000, 9'h111, 9'h000, 9'h0AA, 9'h000, 9'h000};
        pulse_reset();
        for (int k = 0; k < 9; k++) begin
            disp_req = t_disp[k]; disp_addr = 11'h7F0;
            cpu_req = t_req[k]; cpu_we = t_we[k]; cpu_addr = t_addr[k]; cpu_wdata = t_wd[k];
            @(negedge clk);
            vectors += 3;
            if (cpu_ack !== e_ack[k]) begin miscompares++; $display("FAIL wbuf_ack k=%0d: got %b expected %b", k, cpu_ack, e_ack[k]); end
            if (ram_we !== e_we[k]) begin miscompares++; $display("FAIL wbuf_we k=%0d: got %b expected %b", k, ram_we, e_we[k]); end
            if (ram_addr !== e_addr[k]) begin miscompares++; $display("FAIL wbuf_addr k=%0d: got %h expected %h", k, ram_addr, e_addr[k]); end
            if (e_we[k]) begin
                vectors++;
                if (ram_din !== e_din[k]) begin miscompares++; $display("FAIL wbuf_din k=%0d: got %h expected %h", k, ram_din, e_din[k]); end
            end
            if (k == 8) begin
                vectors += 2;
                if (cpu_rvalid !== 1'b1) begin miscompares++; $display("FAIL wbuf_rvalid: got %b expected 1", cpu_rvalid); end
                if (cpu_rdata !== 9'h0AA) begin miscompares++; $display("FAIL wbuf_rdata: got %h expected 0aa", cpu_rdata); end
            end
            tick();
        end
        idle_inputs();
        $display("write buffer: posted write, held second write, blocked read");
    endtask
`endif

    task automatic test_reset_mid();
        pulse_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h010;
        @(negedge clk);
        vectors++;
        if (cpu_ack !== 1'b1) begin miscompares++; $display("FAIL rstmid_grant: got %b expected 1", cpu_ack); end
        tick();
        rst = 1'b1;
        disp_req = 1'b1; disp_addr = 11'h055;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors += 8;
            if (cpu_rvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_rvalid c=%0d: got %b expected 0", c, cpu_rvalid); end
            if (disp_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_dvalid c=%0d: got %b expected 0", c, disp_valid); end
            if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL rstmid_ack c=%0d: got %b expected 0", c, cpu_ack); end
            if (disp_miss !== 1'b0) begin miscompares++; $display("FAIL rstmid_miss c=%0d: got %b expected 0", c, disp_miss); end
            if (ram_we !== 1'b0) begin miscompares++; $display("FAIL rstmid_we c=%0d: got %b expected 0", c, ram_we); end
            if (ram_addr !== '0) begin miscompares++; $display("FAIL rstmid_addr c=%0d: got %h expected 0", c, ram_addr); end
            if (cpu_rdata !== '0) begin miscompares++; $display("FAIL rstmid_rdata c=%0d: got %h expected 0", c, cpu_rdata); end
            if (disp_data !== '0) begin miscompares++; $display("FAIL rstmid_ddata c=%0d: got %h expected 0", c, disp_data); end
            tick();
        end
        rst = 1'b0;
        $display("reset mid-read: return discarded");
        test_starvation(1'b1);
    endtask

    task automatic test_random();
        int win, starve;
        bit take, frc, ack_e, we_e, exp_dv, exp_cv, cur, bfull;
        logic [AW-1:0] addr_e, last_addr, baddr;
        logic [DW-1:0] din_e, pend_dd, pend_cd, hold_dd, hold_cd, bdata, want;
        pulse_reset();
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = ram[a];
        starve = 0; bfull = 1'b0; baddr = '0; bdata = '0; last_addr = '0;
        exp_dv = 1'b0; exp_cv = 1'b0; pend_dd = '0; pend_cd = '0; hold_dd = '0; hold_cd = '0;
        cur = 1'b0;
        for (int i = 0; i < 400; i++) begin
            disp_req = ($urandom_range(0, 9) < ((i < 200) ? 9 : 4));
            disp_addr = AW'($urandom_range(0, 31));
            if (!cur && $urandom_range(0, 2) == 0) begin
                cur = 1'b1;
                cpu_we = $urandom_range(0, 1) == 1;
                cpu_addr = AW'($urandom_range(0, 31));
                cpu_wdata = DW'($urandom);
            end
            cpu_req = cur;
            @(negedge clk);
`ifdef BG_ARB_WBUF_EN
            take = cur && cpu_we && !bfull;
`else
            take = 1'b0;
`endif
            frc = cur && !take && (starve == SM);
            if (frc) win = bfull ? W_DRAIN : W_CPU;
            else if (disp_req) win = W_DISP;
            else if (bfull) win = W_DRAIN;
            else if (cur && !take) win = W_CPU;
            else win = W_NONE;
            ack_e = take || (win == W_CPU);
            we_e = (win == W_DRAIN) || (win == W_CPU && cpu_we);
            case (win)
                W_DISP:  addr_e = disp_addr;
                W_CPU:   addr_e = cpu_addr;
                W_DRAIN: addr_e = baddr;
                default: addr_e = last_addr;
            endcase
            din_e = (win == W_DRAIN) ? bdata : cpu_wdata;

            vectors += 6;
            if (cpu_ack !== ack_e) begin miscompares++; $display("FAIL rnd_ack i=%0d: got %b expected %b", i, cpu_ack, ack_e); end
            if (disp_miss !== (frc && disp_req)) begin miscompares++; $display("FAIL rnd_miss i=%0d: got %b expected %b", i, disp_miss, frc && disp_req); end
            if (ram_we !== we_e) begin miscompares++; $display("FAIL rnd_we i=%0d: got %b expected %b", i, ram_we, we_e); end
            if (ram_addr !== addr_e) begin miscompares++; $display("FAIL rnd_addr i=%0d: got %h expected %h", i, ram_addr, addr_e); end
            if (disp_valid !== exp_dv) begin miscompares++; $display("FAIL rnd_dvalid i=%0d: got %b expected %b", i, disp_valid, exp_dv); end
            if (cpu_rvalid !== exp_cv) begin miscompares++; $display("FAIL rnd_cvalid i=%0d: got %b expected %b", i, cpu_rvalid, exp_cv); end
            want = exp_dv ? pend_dd : hold_dd;
            vectors++;
            if (disp_data !== want) begin miscompares++; $display("FAIL rnd_ddata i=%0d: got %h expected %h", i, disp_data, want); end
            hold_dd = want;
            want = exp_cv ? pend_cd : hold_cd;
            vectors++;
            if (cpu_rdata !== want) begin miscompares++; $display("FAIL rnd_cdata i=%0d: got %h expected %h", i, cpu_rdata, want); end
            hold_cd = want;
            if (we_e) begin
                vectors++;
                if (ram_din !== din_e) begin miscompares++; $display("FAIL rnd_din i=%0d: got %h expected %h", i, ram_din, din_e); end
            end

            exp_dv = (win == W_DISP);
            exp_cv = (win == W_CPU) && !cpu_we;
            if (win == W_DISP) pend_dd = ref_mem[disp_addr];
            if (win == W_CPU && !cpu_we) pend_cd = ref_mem[cpu_addr];
            if (we_e) ref_mem[addr_e] = din_e;
            if (win == W_DRAIN) bfull = 1'b0;
            if (take) begin bfull = 1'b1; baddr = cpu_addr; bdata = cpu_wdata; end
            if (win != W_NONE) last_addr = addr_e;
            if (ack_e || win == W_DRAIN) starve = 0;
            else if (cur && starve < 15) starve++;
            if (ack_e) begin
                $display("random: cpu %s addr 0x%h acked at step %0d%s", cpu_we ? "wr" : "rd", cpu_addr, i, frc ? " (forced)" : "");
                cur = 1'b0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        test_reset();
        test_lone_read();
        pulse_reset();
        test_starvation(1'b0);
        test_write_slot();
`ifdef BG_ARB_WBUF_EN
        test_back_to_back();
`endif
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bg_vram_arbiter.md
BG_VRAM_ARBITER -- requirements
Module: bg_vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, VRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 9, VRAM word width (three 3-bit pixel indices).
REQ-003 SHALL have parameter STARVE_MAX, default 15, the number of consecutive denied CPU cycles before the CPU is forced through.
REQ-004 SHALL have port clk, input, 1, the single clock; every register SHALL be clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port disp_req, input, 1, display fetch request for the current cycle.
REQ-007 SHALL have port disp_addr, input, ADDR_W, display fetch address.
REQ-008 SHALL have port disp_valid, output, 1, display read data valid.
REQ-009 SHALL have port disp_data, output, DATA_W, display read data.
REQ-010 SHALL have port disp_miss, output, 1, pulse: display request denied this cycle.
REQ-011 SHALL have port cpu_req, input, 1, CPU access request, held until acked.
REQ-012 SHALL have port cpu_we, input, 1, CPU write when 1, read when 0.
REQ-013 SHALL have port cpu_addr, input, ADDR_W, CPU access address.
REQ-014 SHALL have port cpu_wdata, input, DATA_W, CPU write data.
REQ-015 SHALL have port cpu_ack, output, 1, one-cycle pulse: CPU request accepted.
REQ-016 SHALL have port cpu_rvalid, output, 1, CPU read data valid.
REQ-017 SHALL have port cpu_rdata, output, DATA_W, CPU read data.
REQ-018 SHALL have port ram_addr, output, ADDR_W, address to the single-port BG VRAM.
REQ-019 SHALL have port ram_we, output, 1, write enable to the single-port BG VRAM.
REQ-020 SHALL have port ram_din, output, DATA_W, write data to the single-port BG VRAM.
REQ-021 SHALL have port ram_dout, input, DATA_W, VRAM read data, valid one cycle after its address.

Function
REQ-022 SHALL grant at most one requester per cycle, with priority: forced CPU (starve_cnt==STARVE_MAX and CPU pending) > display > buffered-write drain > direct CPU.
REQ-023 SHALL drive ram_addr/ram_we/ram_din combinationally from the current-cycle grant; when there is no grant, ram_we SHALL be 0 and ram_addr SHALL hold its last value.
REQ-024 SHALL keep a registered owner state {IDLE, DISP, CPU_RD, CPU_WR} recording the grant of the previous cycle.
REQ-025 SHALL assert disp_valid in cycle N+1 with disp_data=ram_dout when owner==DISP.
REQ-026 SHALL assert cpu_rvalid in cycle N+1 with cpu_rdata=ram_dout when owner==CPU_RD; both data outputs SHALL hold their value otherwise.
REQ-027 SHALL pulse cpu_ack in the cycle a CPU access is granted (or buffered, see REQ-034), with at most one ack per cycle; a still-high cpu_req in the following cycle SHALL be treated as a new request.
REQ-028 SHALL maintain starve_cnt, a 4-bit saturating counter: +1 each cycle a CPU access is pending and not granted, cleared on a CPU grant or a drain.
REQ-029 SHALL pulse disp_miss only when a forced CPU grant displaces disp_req.
REQ-030 SHALL, on simultaneous disp_req and cpu_req with starve_cnt<STARVE_MAX, grant the display and increment starve_cnt.

Reset
REQ-031 SHALL, while rst is high, set owner=IDLE, starve_cnt=0, the write buffer empty, disp_valid=0, cpu_ack=0, cpu_rvalid=0, disp_miss=0, ram_we=0, and ram_addr, disp_data, cpu_rdata to 0.
REQ-032 SHALL, on reset asserted mid-transaction, discard any pending read return and buffered write; no valid or ack SHALL be produced in the cycle after reset deasserts.

Configuration
REQ-033 SHALL compile in the write buffer only when macro BG_ARB_WBUF_EN is defined.
REQ-034 SHALL, with BG_ARB_WBUF_EN, provide a one-entry posted write buffer: a CPU write arriving with the buffer empty is acked that cycle, stored, and drained in the next slot free of the display; a write arriving with the buffer full waits for the drain; a CPU read is not granted while the buffer is full.
REQ-035 SHALL, without BG_ARB_WBUF_EN, ack a CPU write only in the cycle it wins the VRAM port.

Verification
REQ-036 SHALL be verified by a bench covering: lone CPU read of addr 0x010 with RAM holding 0x1A5 -> cpu_ack in cycle N, cpu_rvalid=1 and cpu_rdata=0x1A5 in N+1.
REQ-037 SHALL be verified by a bench covering: disp_req and cpu_req (read) both held high continuously -> display granted 15 cycles, forced CPU grant in cycle 16 with disp_miss=1, then starve_cnt=0.
REQ-038 SHALL be verified by a bench covering: display requesting every third cycle plus a CPU write of 0x0FF to 0x123 -> write lands in the first free slot with ram_we=1, ram_addr=0x123, ram_din=0x0FF, and no disp_miss.
REQ-039 SHALL be verified by a bench covering, with BG_ARB_WBUF_EN: CPU write while the display is busy -> cpu_ack the same cycle; a back-to-back second write is held until the drain; a read issued while the buffer is full waits.
REQ-040 SHALL be verified by a bench covering: rst asserted in the cycle after a CPU read grant -> cpu_rvalid stays 0, all outputs read 0, and starve_cnt=0 after release.
